fw_header_classifier: RTL and testbench

- Consumer of the header FIFO fed by the MAC/PRT dispatcher.
- Pops one extracted header (id, PRT slot tag, 5-tuple) at a time and scans a programmable first-match rule table, one rule per cycle.
- Returns a permit/deny verdict (id, tag, result) to the dispatcher, which routes permits to its send queue and denies to its invalidate queue.

---
 rtl/fw_header_classifier.sv | 220 ++++++++++++++++++++++
 tb/tb_fw_header_classifier.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_header_classifier.sv
// First-match 5-tuple firewall classifier: pops one header, scans the rule
// table one rule per cycle, and returns a permit/deny verdict.
module fw_header_classifier #(
  parameter int NUM_RULES      = 8,
  parameter int TAG_W          = 2,
  parameter bit DEFAULT_PERMIT = 1'b0,
  parameter int RI_W           = $clog2(NUM_RULES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  input  logic                         hdr_id,
  input  logic [TAG_W-1:0]             hdr_tag,
  input  logic [7:0]                   hdr_protocol,
  input  logic [31:0]                  hdr_srcip,
  input  logic [31:0]                  hdr_dstip,
  input  logic [15:0]                  hdr_srcport,
  input  logic [15:0]                  hdr_dstport,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_id,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         res_permit,
  output logic                         res_hit,
  output logic [RI_W-1:0]              res_rule,
  input  logic                         cfg_we,
  output logic                         cfg_ready,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_idx,
  input  logic                         cfg_en,
  input  logic                         cfg_permit,
  input  logic                         cfg_proto_any,
  input  logic [7:0]                   cfg_protocol,
  input  logic [31:0]                  cfg_srcip,
  input  logic [5:0]                   cfg_src_plen,
  input  logic [31:0]                  cfg_dstip,
  input  logic [5:0]                   cfg_dst_plen,
  input  logic [15:0]                  cfg_dport_lo,
  input  logic [15:0]                  cfg_dport_hi,
  output logic [15:0]                  permit_cnt,
  output logic [15:0]                  deny_cnt
);

  localparam int IW = $clog2(NUM_RULES);
  localparam logic [IW-1:0] LAST = IW'(NUM_RULES - 1);

  typedef struct packed {
    logic        en;
    logic        permit;
    logic        proto_any;
    logic [7:0]  protocol;
    logic [31:0] srcip;
    logic [5:0]  src_plen;
    logic [31:0] dstip;
    logic [5:0]  dst_plen;
    logic [15:0] dport_lo;
    logic [15:0] dport_hi;
  } rule_t;

  // srcport travels with the header upstream but never takes part in matching
  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [7:0]       protocol;
    logic [31:0]      srcip;
    logic [31:0]      dstip;
    logic [15:0]      dstport;
  } hdr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  rule_t             rules_q [NUM_RULES];
  rule_t             rules_d [NUM_RULES];
  hdr_t              hdr_q, hdr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              res_id_q, res_id_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_permit_q, res_permit_d;
  logic              res_hit_q, res_hit_d;
  logic [RI_W-1:0]   res_rule_q, res_rule_d;
  logic [15:0]       permit_cnt_q, permit_cnt_d;
  logic [15:0]       deny_cnt_q, deny_cnt_d;
  rule_t             cur;

  function automatic logic [31:0] pmask(input logic [5:0] plen);
    logic [5:0] p;
    p = (plen > 6'd32) ? 6'd32 : plen;
    if (p == 6'd0) return 32'h0;
    return ~32'h0 << (6'd32 - p);
  endfunction

  function automatic logic rule_match(input rule_t r, input hdr_t h);
    logic m_proto, m_src, m_dst, m_port;
    m_proto = r.proto_any || (r.protocol == h.protocol);
    m_src   = ((h.srcip ^ r.srcip) & pmask(r.src_plen)) == 32'h0;
    m_dst   = ((h.dstip ^ r.dstip) & pmask(r.dst_plen)) == 32'h0;
    m_port  = (h.dstport >= r.dport_lo) && (h.dstport <= r.dport_hi);
    return m_proto && m_src && m_dst && m_port;
  endfunction

  assign hdr_ready  = rst && (state_q == S_IDLE);
  assign cfg_ready  = rst && (state_q == S_IDLE);
  assign res_valid  = (state_q == S_RESP);
  assign res_id     = res_id_q;
  assign res_tag    = res_tag_q;
  assign res_permit = res_permit_q;
  assign res_hit    = res_hit_q;
  assign res_rule   = res_rule_q;
  assign permit_cnt = permit_cnt_q;
  assign deny_cnt   = deny_cnt_q;

  always_comb begin
    state_d      = state_q;
    rules_d      = rules_q;
    hdr_d        = hdr_q;
    idx_d        = idx_q;
    res_id_d     = res_id_q;
    res_tag_d    = res_tag_q;
    res_permit_d = res_permit_q;
    res_hit_d    = res_hit_q;
    res_rule_d   = res_rule_q;
    permit_cnt_d = permit_cnt_q;
    deny_cnt_d   = deny_cnt_q;
    cur          = rules_q[idx_q];

    if (cfg_we && cfg_ready) begin
      rules_d[cfg_idx] = '{
        en:        cfg_en,
        permit:    cfg_permit,
        proto_any: cfg_proto_any,
        protocol:  cfg_protocol,
        srcip:     cfg_srcip,
        src_plen:  cfg_src_plen,
        dstip:     cfg_dstip,
        dst_plen:  cfg_dst_plen,
        dport_lo:  cfg_dport_lo,
        dport_hi:  cfg_dport_hi
      };
    end

    unique case (state_q)
      S_IDLE: begin
        if (hdr_valid && hdr_ready) begin
          hdr_d = '{
            id:       hdr_id,
            tag:      hdr_tag,
            protocol: hdr_protocol,
            srcip:    hdr_srcip,
            dstip:    hdr_dstip,
            dstport:  hdr_dstport
          };
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        res_id_d  = hdr_q.id;
        res_tag_d = hdr_q.tag;
        if (cur.en && rule_match(cur, hdr_q)) begin
          res_permit_d = cur.permit;
          res_hit_d    = 1'b1;
          res_rule_d   = RI_W'(idx_q);
          state_d      = S_RESP;
        end else if (idx_q == LAST) begin
          res_permit_d = DEFAULT_PERMIT;
          res_hit_d    = 1'b0;
          res_rule_d   = RI_W'(NUM_RULES);
          state_d      = S_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          if (res_permit_q) begin
            if (permit_cnt_q != 16'hFFFF) permit_cnt_d = permit_cnt_q + 16'd1;
          end else begin
            if (deny_cnt_q != 16'hFFFF) deny_cnt_d = deny_cnt_q + 16'd1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < NUM_RULES; i++) rules_q[i] <= '0;
      hdr_q        <= '0;
      idx_q        <= '0;
      res_id_q     <= 1'b0;
      res_tag_q    <= '0;
      res_permit_q <= 1'b0;
      res_hit_q    <= 1'b0;
      res_rule_q   <= '0;
      permit_cnt_q <= 16'h0;
      deny_cnt_q   <= 16'h0;
    end else begin
      state_q      <= state_d;
      rules_q      <= rules_d;
      hdr_q        <= hdr_d;
      idx_q        <= idx_d;
      res_id_q     <= res_id_d;
      res_tag_q    <= res_tag_d;
      res_permit_q <= res_permit_d;
      res_hit_q    <= res_hit_d;
      res_rule_q   <= res_rule_d;
      permit_cnt_q <= permit_cnt_d;
      deny_cnt_q   <= deny_cnt_d;
    end
  end

endmodule

// File: tb/tb_fw_header_classifier.sv
// Directed bench for fw_header_classifier with a first-match reference
// model and a per-cycle compare process.
module tb_fw_header_classifier;

  localparam int N   = 8;
  localparam int TW  = 2;
  localparam int RIW = 4;
  localparam bit DP  = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hdr_valid = 1'b0;
  logic          hdr_ready;
  logic          hdr_id = 1'b0;
  logic [TW-1:0] hdr_tag = '0;
  logic [7:0]    hdr_protocol = '0;
  logic [31:0]   hdr_srcip = '0;
  logic [31:0]   hdr_dstip = '0;
  logic [15:0]   hdr_srcport = '0;
  logic [15:0]   hdr_dstport = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic          res_id;
  logic [TW-1:0] res_tag;
  logic          res_permit;
  logic          res_hit;
  logic [RIW-1:0] res_rule;
  logic          cfg_we = 1'b0;
  logic          cfg_ready;
  logic [2:0]    cfg_idx = '0;
  logic          cfg_en = 1'b0;
  logic          cfg_permit = 1'b0;
  logic          cfg_proto_any = 1'b0;
  logic [7:0]    cfg_protocol = '0;
  logic [31:0]   cfg_srcip = '0;
  logic [5:0]    cfg_src_plen = '0;
  logic [31:0]   cfg_dstip = '0;
  logic [5:0]    cfg_dst_plen = '0;
  logic [15:0]   cfg_dport_lo = '0;
  logic [15:0]   cfg_dport_hi = '0;
  logic [15:0]   permit_cnt;
  logic [15:0]   deny_cnt;

  fw_header_classifier #(
    .NUM_RULES(N), .TAG_W(TW), .DEFAULT_PERMIT(DP), .RI_W(RIW)
  ) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_id(hdr_id), .hdr_tag(hdr_tag), .hdr_protocol(hdr_protocol),
    .hdr_srcip(hdr_srcip), .hdr_dstip(hdr_dstip),
    .hdr_srcport(hdr_srcport), .hdr_dstport(hdr_dstport),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_tag(res_tag), .res_permit(res_permit),
    .res_hit(res_hit), .res_rule(res_rule),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_permit(cfg_permit),
    .cfg_proto_any(cfg_proto_any), .cfg_protocol(cfg_protocol),
    .cfg_srcip(cfg_srcip), .cfg_src_plen(cfg_src_plen),
    .cfg_dstip(cfg_dstip), .cfg_dst_plen(cfg_dst_plen),
    .cfg_dport_lo(cfg_dport_lo), .cfg_dport_hi(cfg_dport_hi),
    .permit_cnt(permit_cnt), .deny_cnt(deny_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        en;
    bit        permit;
    bit        any;
    bit [7:0]  proto;
    bit [31:0] sip;
    int        splen;
    bit [31:0] dip;
    int        dplen;
    int        lo;
    int        hi;
  } mrule_t;

  mrule_t mr [N];
  mrule_t stg;
  int     stg_idx;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit armed = 0;

  bit pending = 0;
  int exp_start = 0;
  int t_hs = 0;
  bit e_id;
  bit [TW-1:0] e_tag;
  bit e_permit;
  bit e_hit;
  int e_rule;
  int pcnt = 0;
  int dcnt = 0;

  bit seen = 0;
  int seen_cyc = -1;
  int seen_rule = -1;
  int seen_permit = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit pfx(bit [31:0] a, bit [31:0] b, int n);
    if (n > 32) n = 32;
    if (n == 0) return 1'b1;
    return (a >> (32 - n)) == (b >> (32 - n));
  endfunction

  // First enabled rule whose every field accepts the header; N when none does.
  function automatic int classify(bit [7:0] pr, bit [31:0] s, bit [31:0] d,
                                  int dp);
    for (int i = 0; i < N; i++) begin
      if (mr[i].en && (mr[i].any || mr[i].proto == pr) &&
          pfx(s, mr[i].sip, mr[i].splen) && pfx(d, mr[i].dip, mr[i].dplen) &&
          dp >= mr[i].lo && dp <= mr[i].hi)
        return i;
    end
    return N;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      if (!rst) begin
        chk("hdr_ready_in_reset", hdr_ready, 0);
      end else begin
        bit ev;
        ev = pending && (cyc >= exp_start);
        chk("res_valid", res_valid, ev);
        chk("hdr_ready", hdr_ready, !pending);
        chk("cfg_ready", cfg_ready, !pending);
        chk("permit_cnt", permit_cnt, pcnt);
        chk("deny_cnt", deny_cnt, dcnt);
        if (ev) begin
          chk("res_id", res_id, e_id);
          chk("res_tag", res_tag, e_tag);
          chk("res_permit", res_permit, e_permit);
          chk("res_hit", res_hit, e_hit);
          chk("res_rule", res_rule, e_rule);
        end
        if (res_valid && !seen) begin
          seen        = 1;
          seen_cyc    = cyc;
          seen_rule   = int'(res_rule);
          seen_permit = int'(res_permit);
        end
      end
    end
  end

  // One clock; the model tracks every handshake the DUT should take.
  task automatic tick();
    bit ac, ah, ar;
    int r;
    ac = cfg_we && rst && !pending;
    ah = hdr_valid && rst && !pending;
    ar = res_ready && rst && pending && (cyc >= exp_start);
    @(posedge clk);
    #1;
    if (ac) mr[stg_idx] = stg;
    cfg_we = 1'b0;
    if (ar) begin
      if (e_permit) pcnt = (pcnt < 65535) ? pcnt + 1 : pcnt;
      else          dcnt = (dcnt < 65535) ? dcnt + 1 : dcnt;
      pending = 0;
    end
    if (ah) begin
      hdr_valid = 1'b0;
      r         = classify(hdr_protocol, hdr_srcip, hdr_dstip, int'(hdr_dstport));
      t_hs      = cyc - 1;
      e_id      = hdr_id;
      e_tag     = hdr_tag;
      e_hit     = (r < N);
      e_permit  = (r < N) ? mr[r].permit : DP;
      e_rule    = r;
      exp_start = t_hs + ((r < N) ? r + 2 : N + 1);
      pending   = 1;
      seen      = 0;
      seen_cyc  = -1;
    end
  endtask

  task automatic set_rule(int idx, bit en, bit pm, bit any, bit [7:0] pr,
                          bit [31:0] sip, int spl, bit [31:0] dip, int dpl,
                          int lo, int hi);
    stg = '{en, pm, any, pr, sip, spl, dip, dpl, lo, hi};
    stg_idx       = idx;
    cfg_idx       = 3'(idx);
    cfg_en        = en;
    cfg_permit    = pm;
    cfg_proto_any = any;
    cfg_protocol  = pr;
    cfg_srcip     = sip;
    cfg_src_plen  = 6'(spl);
    cfg_dstip     = dip;
    cfg_dst_plen  = 6'(dpl);
    cfg_dport_lo  = 16'(lo);
    cfg_dport_hi  = 16'(hi);
    cfg_we        = 1'b1;
  endtask

  task automatic set_hdr(bit id, bit [TW-1:0] tag, bit [7:0] pr,
                         bit [31:0] sip, bit [31:0] dip, int dport);
    hdr_id       = id;
    hdr_tag      = tag;
    hdr_protocol = pr;
    hdr_srcip    = sip;
    hdr_dstip    = dip;
    hdr_srcport  = 16'(1000 + dport);
    hdr_dstport  = 16'(dport);
    hdr_valid    = 1'b1;
  endtask

  task automatic wait_done(int hold);
    int n = 0;
    res_ready = (hold == 0);
    while (pending && n < 300) begin
      if (hold > 0 && n == hold) res_ready = 1'b1;
      tick();
      n++;
    end
    res_ready = 1'b1;
    if (pending) begin
      vecs++;
      errs++;
      $display("FAIL resp_timeout: verdict not accepted within %0d cycles", n);
      pending = 0;
    end
  endtask

  task automatic run_hdr(bit id, bit [TW-1:0] tag, bit [7:0] pr,
                         bit [31:0] sip, bit [31:0] dip, int dport);
    set_hdr(id, tag, pr, sip, dip, dport);
    tick();
    wait_done(0);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    pending = 0;
    for (int i = 0; i < N; i++) mr[i].en = 0;
    pcnt = 0;
    dcnt = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mr[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tick();
    tick();
    rst   = 1'b1;
    armed = 1;
    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_rule", res_rule, 0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_hdr_ready", hdr_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);

    // empty table: default deny after full scan
    run_hdr(1, 2, 6, 32'h01020304, 32'h0A000001, 80);
    chk("t1_latency", seen_cyc - t_hs, 9);
    chk("t1_rule", seen_rule, 8);
    chk("t1_permit", seen_permit, 0);
    chk("t1_deny_cnt", deny_cnt, 1);

    // rule 3: tcp to 10/8 port 80
    set_rule(3, 1, 1, 0, 6, 0, 0, 32'h0A000000, 8, 80, 80);
    tick();
    run_hdr(0, 1, 6, 32'hC0A80101, 32'h0A010203, 80);
    chk("t2_latency", seen_cyc - t_hs, 5);
    chk("t2_rule", seen_rule, 3);
    chk("t2_permit", seen_permit, 1);
    run_hdr(0, 1, 6, 32'hC0A80101, 32'h0A010203, 81);
    chk("t2b_rule", seen_rule, 8);

    // first match wins
    set_rule(0, 1, 0, 1, 0, 32'hC0A80100, 24, 0, 0, 0, 16'hFFFF);
    tick();
    set_rule(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    tick();
    run_hdr(1, 3, 17, 32'hC0A80107, 32'h08080808, 53);
    chk("t3a_rule", seen_rule, 0);
    chk("t3a_permit", seen_permit, 0);
    run_hdr(1, 0, 17, 32'hC0A80207, 32'h08080808, 53);
    chk("t3b_rule", seen_rule, 1);
    chk("t3b_latency", seen_cyc - t_hs, 3);

    // back-pressure: verdict held ~28 cycles
    set_hdr(0, 2, 1, 32'hC0A80209, 32'h01010101, 7);
    tick();
    wait_done(30);
    chk("t4_permit_cnt", permit_cnt, 3);

    // config write during scan is dropped
    set_hdr(1, 1, 6, 32'hC0A80209, 32'h01010101, 7);
    tick();
    set_rule(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    tick();
    wait_done(0);
    run_hdr(0, 1, 6, 32'hC0A80209, 32'h01010101, 7);
    chk("t5_rule_kept", seen_rule, 1);
    chk("t5_permit_kept", seen_permit, 1);

    // inverted port range never matches
    set_rule(1, 1, 1, 1, 0, 0, 0, 0, 0, 100, 50);
    tick();
    for (int p = 0; p < 3; p++) begin
      run_hdr(0, 0, 6, 32'hC0A80209, 32'h01010101, 50 + 25 * p);
      chk("t6_inverted_range", seen_rule, 8);
    end

    // write and header accepted in the same cycle
    set_rule(2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF);
    set_hdr(1, 2, 6, 32'hC0A80505, 32'h01010101, 9);
    tick();
    wait_done(0);
    chk("t7_same_cycle_rule", seen_rule, 2);

    // reset mid-scan drops the header and clears the table
    set_hdr(1, 3, 6, 32'h0B000001, 32'h0C000001, 9);
    tick();
    tick();
    do_reset();
    @(negedge clk);
    chk("t8_permit_cnt", permit_cnt, 0);
    chk("t8_deny_cnt", deny_cnt, 0);
    run_hdr(1, 0, 6, 32'hC0A80107, 32'h01010101, 9);
    chk("t8_default_rule", seen_rule, 8);
    chk("t8_latency", seen_cyc - t_hs, 9);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
